// File: rtl/br_credit_receiver_fifo.sv
// -----------------------------------------------------------------------------
// br_credit_receiver_fifo
//
// Receiver side of a credit-based link. Incoming beats are written into a
// MaxCredit-deep FIFO without backpressure and drained through a ready/valid
// interface. Each popped entry becomes a credit that is handed back to the
// sender, at most PushCreditMaxChange per cycle, minus any credits that are
// held back by credit_withhold.
//
// Ports
//   clk                    : clock, all state on the rising edge
//   rst_n                  : asynchronous active-low reset
//   push_sender_in_reset   : sender is in reset; flush FIFO, reload counter
//   push_receiver_in_reset : this receiver is in reset (released one edge
//                            after rst_n rises)
//   push_credit_stall      : suppress credit return this cycle
//   push_credit            : credits returned to the sender this cycle
//   push_valid / push_data : credited data beat (always accepted)
//   pop_ready / pop_valid / pop_data : ready/valid drain of the FIFO
//   credit_initial         : value the credit counter restarts from
//   credit_withhold        : credits kept back from return
//   credit_count           : current credit counter
//   credit_available       : credits currently eligible for return
// -----------------------------------------------------------------------------
module br_credit_receiver_fifo #(
    parameter int Width               = 8,
    parameter int MaxCredit           = 4,
    parameter int PushCreditMaxChange = 1,
    localparam int CounterWidth       = $clog2(MaxCredit + 1),
    localparam int PushCreditWidth    = $clog2(PushCreditMaxChange + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_sender_in_reset,
    output logic                       push_receiver_in_reset,
    input  logic                       push_credit_stall,
    output logic [PushCreditWidth-1:0] push_credit,
    input  logic                       push_valid,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop_ready,
    output logic                       pop_valid,
    output logic [Width-1:0]           pop_data,
    input  logic [CounterWidth-1:0]    credit_initial,
    input  logic [CounterWidth-1:0]    credit_withhold,
    output logic [CounterWidth-1:0]    credit_count,
    output logic [CounterWidth-1:0]    credit_available
);

    localparam int PtrWidth = (MaxCredit > 1) ? $clog2(MaxCredit) : 1;
    localparam logic [PtrWidth-1:0]     LastPtr   = PtrWidth'(MaxCredit - 1);
    localparam logic [CounterWidth-1:0] CreditCap = CounterWidth'(PushCreditMaxChange);
    localparam logic [CounterWidth-1:0] FullOcc   = CounterWidth'(MaxCredit);

    logic                    in_reset_reg;
    logic [CounterWidth-1:0] count_reg, count_next;
    logic [CounterWidth-1:0] occ_reg, occ_next;
    logic [PtrWidth-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [Width-1:0]        mem [MaxCredit];

    logic                    hold;
    logic                    push;
    logic                    pop;
    logic [CounterWidth-1:0] credit_return;

    // Set asynchronously, released on the first edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reset_reg <= 1'b1;
        end else begin
            in_reset_reg <= 1'b0;
        end
    end

    assign push_receiver_in_reset = in_reset_reg;

    // Either side being in reset pins the counter to its initial value and
    // keeps the FIFO empty.
    assign hold = in_reset_reg | push_sender_in_reset;

    // The counter register cannot be asynchronously loaded from an input, so
    // the reload value is presented combinationally while in reset and the
    // register itself picks it up on the following edge.
    assign credit_count = hold ? credit_initial : count_reg;

    assign credit_available = (credit_count > credit_withhold) ?
                              (credit_count - credit_withhold) : '0;

    assign credit_return = (credit_available > CreditCap) ? CreditCap : credit_available;

    assign push_credit = (push_credit_stall || hold) ? '0
                                                     : PushCreditWidth'(credit_return);

    assign pop_valid = (occ_reg != '0);
    assign pop_data  = mem[rd_ptr_reg];
    assign pop       = pop_valid & pop_ready;
    assign push      = push_valid & ~hold;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        count_next  = count_reg;
        if (hold) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            occ_next    = '0;
            count_next  = credit_initial;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range.
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
            end
            occ_next   = occ_reg + CounterWidth'(push) - CounterWidth'(pop);
            count_next = count_reg + CounterWidth'(pop) - CounterWidth'(push_credit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; validity is tracked by occ_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Protocol guarantees: a credited sender never overruns the buffer and the
    // counter never exceeds its ceiling.
    push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (occ_reg == FullOcc)));

    count_ceiling_a : assert property (@(posedge clk) disable iff (!rst_n)
        count_reg <= FullOcc);

endmodule

// File: tb/tb_br_credit_receiver_fifo.sv
// -----------------------------------------------------------------------------
// Bench for br_credit_receiver_fifo (default parameters: Width 8, MaxCredit 4,
// PushCreditMaxChange 1). The bench plays the credit sender: it only pushes
// when it holds a credit. Expected beats are queued at the push edge; a
// monitor on the falling edge compares FIFO output and credit behaviour
// against a counting model of the credit rules.
// -----------------------------------------------------------------------------
module tb_br_credit_receiver_fifo;

    localparam int W   = 8;
    localparam int MC  = 4;
    localparam int PC  = 1;
    localparam int CW  = $clog2(MC + 1);
    localparam int PCW = $clog2(PC + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           push_sender_in_reset;
    logic           push_receiver_in_reset;
    logic           push_credit_stall;
    logic [PCW-1:0] push_credit;
    logic           push_valid;
    logic [W-1:0]   push_data;
    logic           pop_ready;
    logic           pop_valid;
    logic [W-1:0]   pop_data;
    logic [CW-1:0]  credit_initial;
    logic [CW-1:0]  credit_withhold;
    logic [CW-1:0]  credit_count;
    logic [CW-1:0]  credit_available;

    always #5 clk = ~clk;

    br_credit_receiver_fifo #(
        .Width(W),
        .MaxCredit(MC),
        .PushCreditMaxChange(PC)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .push_sender_in_reset   (push_sender_in_reset),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_credit_stall      (push_credit_stall),
        .push_credit            (push_credit),
        .push_valid             (push_valid),
        .push_data              (push_data),
        .pop_ready              (pop_ready),
        .pop_valid              (pop_valid),
        .pop_data               (pop_data),
        .credit_initial         (credit_initial),
        .credit_withhold        (credit_withhold),
        .credit_count           (credit_count),
        .credit_available       (credit_available)
    );

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] exp_q[$];
    int         model_count   = MC;
    int         sender_credit = 0;
    bit         model_rir     = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard input: a beat is owed to the pop side from the edge that
    // accepts it.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && push_valid && !push_sender_in_reset) begin
                exp_q.push_back(push_data);
            end
        end
    end

    // Monitor: compare outputs against the credit model, then advance it.
    initial begin
        int  exp_count;
        int  avail;
        int  exp_pc;
        bit  exp_pv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rir", int'(push_receiver_in_reset), 1);
                chk("rst_pop_valid", int'(pop_valid), 0);
                chk("rst_push_credit", int'(push_credit), 0);
                chk("rst_count", int'(credit_count), int'(credit_initial));
                exp_q.delete();
                model_count   = int'(credit_initial);
                sender_credit = 0;
                model_rir     = 1'b1;
            end else begin
                exp_pv = (exp_q.size() != 0);
                chk("pop_valid", int'(pop_valid), int'(exp_pv));
                chk("rir", int'(push_receiver_in_reset), int'(model_rir));
                exp_count = (push_sender_in_reset || model_rir) ? int'(credit_initial) : model_count;
                chk("credit_count", int'(credit_count), exp_count);
                avail = (exp_count > int'(credit_withhold)) ? exp_count - int'(credit_withhold) : 0;
                chk("credit_available", int'(credit_available), avail);
                exp_pc = (push_credit_stall || push_sender_in_reset || model_rir) ? 0
                         : ((avail > PC) ? PC : avail);
                chk("push_credit", int'(push_credit), exp_pc);
                if (exp_pv && pop_ready) begin
                    chk("pop_data", int'(pop_data), int'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (push_sender_in_reset || model_rir) begin
                    if (push_sender_in_reset) begin
                        exp_q.delete();
                        sender_credit = 0;
                    end
                    model_count = int'(credit_initial);
                end else begin
                    model_count   = model_count + int'(exp_pv && pop_ready) - exp_pc;
                    sender_credit = sender_credit + exp_pc;
                end
                model_rir = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of sender stimulus; a push consumes one sender credit.
    task automatic drive(input bit pv, input logic [W-1:0] d, input bit pr);
        if (pv && sender_credit == 0) begin
            checks++;
            errors++;
            $display("FAIL credit_starved actual=0 required=1 t=%0t", $time);
        end
        push_valid = pv && (sender_credit > 0);
        if (push_valid) sender_credit--;
        push_data = d;
        pop_ready = pr;
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            push_sender_in_reset = ($urandom_range(0, 99) == 0);
            push_credit_stall    = ($urandom_range(0, 3) == 0);
            credit_withhold      = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 7)) : '0;
            if (push_sender_in_reset) begin
                drive(1'b0, '0, 1'($urandom_range(0, 1)));
            end else begin
                drive(($urandom_range(0, 1) == 1) && (sender_credit > 0),
                      W'($urandom), 1'($urandom_range(0, 1)));
            end
            cyc();
        end
        push_sender_in_reset = 1'b0;
        push_credit_stall    = 1'b0;
        credit_withhold      = '0;
    endtask

    task automatic drain(input int n);
        drive(1'b0, '0, 1'b1);
        repeat (n) cyc();
    endtask

    initial begin
        rst_n                = 1'b0;
        push_sender_in_reset = 1'b0;
        push_credit_stall    = 1'b0;
        push_valid           = 1'b0;
        push_data            = '0;
        pop_ready            = 1'b0;
        credit_initial       = CW'(MC);
        credit_withhold      = '0;

        // Reset state and release timing.
        repeat (3) cyc();
        chk("reset_pop_valid", int'(pop_valid), 0);
        chk("reset_rir", int'(push_receiver_in_reset), 1);
        chk("reset_count", int'(credit_count), MC);
        rst_n = 1'b1;
        #1;
        chk("release_rir_held", int'(push_receiver_in_reset), 1);
        cyc();
        chk("release_rir_clear", int'(push_receiver_in_reset), 0);

        // Initial credits flow back one per cycle: 4,3,2,1,0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("init_credit", int'(push_credit), (i < 4) ? 1 : 0);
            chk("init_count", int'(credit_count), (i < 4) ? 4 - i : 0);
        end
        cyc();

        // Back-to-back beats, each visible one cycle after its push.
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] d;
            d = W'(8'hA0 + k);
            drive(1'b1, d, 1'b1);
            cyc();
            chk("stream_data", int'(pop_data), int'(d));
        end
        drain(8);

        // Full FIFO held without draining: output stable, no credits.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(8'hC0 + k), 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("full_data", int'(pop_data), 'hC0);
            chk("full_credit", int'(push_credit), 0);
            chk("full_count", int'(credit_count), 0);
        end
        drain(10);

        // Withhold: count 3 with withhold 2 returns 1; raising to 5 stops it.
        credit_withhold = CW'(4);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'(8'h30 + k), 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1);
        repeat (3) cyc();
        chk("wh_count", int'(credit_count), 3);
        credit_withhold = CW'(2);
        #1;
        chk("wh2_credit", int'(push_credit), 1);
        chk("wh2_avail", int'(credit_available), 1);
        credit_withhold = CW'(5);
        #1;
        chk("wh5_credit", int'(push_credit), 0);
        chk("wh5_avail", int'(credit_available), 0);
        credit_withhold = '0;
        drain(8);

        // Sender reset with two buffered beats.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, W'(8'h70 + k), 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        push_sender_in_reset = 1'b1;
        #1;
        chk("sr_credit_now", int'(push_credit), 0);
        chk("sr_count_now", int'(credit_count), MC);
        cyc();
        chk("sr_pop_valid", int'(pop_valid), 0);
        chk("sr_count", int'(credit_count), MC);
        chk("sr_credit", int'(push_credit), 0);
        cyc();
        push_sender_in_reset = 1'b0;
        drain(8);

        random_traffic(1500);
        drain(10);

        // Receiver reset mid-traffic while a beat is buffered.
        drive(1'b1, W'(8'h55), 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        chk("rr_pre_valid", int'(pop_valid), 1);
        credit_initial = CW'(3);
        rst_n = 1'b0;
        #1;
        chk("rr_pop_valid", int'(pop_valid), 0);
        chk("rr_rir", int'(push_receiver_in_reset), 1);
        chk("rr_count", int'(credit_count), 3);
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        chk("rr_rir_held", int'(push_receiver_in_reset), 1);
        cyc();
        chk("rr_rir_clear", int'(push_receiver_in_reset), 0);

        random_traffic(400);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
